// File: rtl/multi_linked_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multi_linked_list                                          |
// | Description : NUM_LISTS singly linked lists sharing one node pool, with  |
// |               a bitmap allocator and an op/op_start/op_done handshake.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module multi_linked_list #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_NODE   = 16,
    parameter  int NUM_LISTS  = 4,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1),
    localparam int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    input  logic [2:0]            op,
    input  logic [LIST_WIDTH-1:0] list_sel,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  op_done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] node_addr,
    output logic [ADDR_WIDTH-1:0] next_node_addr,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic [ADDR_WIDTH-1:0] length,
    output logic [NUM_LISTS-1:0]  list_empty,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] free_count
);

    localparam int IDX_WIDTH = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_null = ADDR_WIDTH'(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] c_one  = ADDR_WIDTH'(1);

    localparam logic [2:0] c_op_read     = 3'd0;
    localparam logic [2:0] c_op_ins_head = 3'd1;
    localparam logic [2:0] c_op_ins_tail = 3'd2;
    localparam logic [2:0] c_op_pop_head = 3'd3;
    localparam logic [2:0] c_op_ins_aft  = 3'd4;
    localparam logic [2:0] c_op_del_aft  = 3'd5;
    localparam logic [2:0] c_op_flush    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [DATA_WIDTH-1:0] r_node_data  [MAX_NODE];
    logic [ADDR_WIDTH-1:0] r_node_next  [MAX_NODE];
    logic [LIST_WIDTH-1:0] r_node_owner [MAX_NODE];
    logic [MAX_NODE-1:0]   r_node_valid;
    logic [ADDR_WIDTH-1:0] r_head [NUM_LISTS];
    logic [ADDR_WIDTH-1:0] r_tail [NUM_LISTS];
    logic [ADDR_WIDTH-1:0] r_len  [NUM_LISTS];

    logic [2:0]            r_op;
    logic [LIST_WIDTH-1:0] r_list;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    logic [ADDR_WIDTH-1:0] w_free_cnt;
    logic [IDX_WIDTH-1:0]  w_alloc_idx;
    logic                  w_alloc_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (op_start) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign op_done = (r_state == S_DONE);

    // ---------------- Live pool status ----------------
    always_comb begin
        w_free_cnt  = '0;
        w_alloc_idx = '0;
        w_alloc_ok  = 1'b0;
        for (int i = 0; i < MAX_NODE; i++)
            w_free_cnt = w_free_cnt + (r_node_valid[i] ? '0 : c_one);
        // Descending scan leaves the lowest free index as the winner.
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (!r_node_valid[i]) begin
                w_alloc_ok  = 1'b1;
                w_alloc_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign free_count = w_free_cnt;
    assign full       = !w_alloc_ok;

    generate
        for (genvar g = 0; g < NUM_LISTS; g++) begin : g_empty
            assign list_empty[g] = (r_len[g] == '0);
        end
    endgenerate

    // ---------------- Command decode / next state ----------------
    logic                  w_list_ok, w_addr_ok, w_empty;
    logic [LIST_WIDTH-1:0] w_lidx;
    logic [IDX_WIDTH-1:0]  w_aidx, w_hidx, w_tidx, w_vidx;
    logic [ADDR_WIDTH-1:0] w_cur_head, w_cur_tail, w_cur_len, w_a_next, w_alloc_addr;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_head_n, w_tail_n, w_len_n;
    logic                  w_new_en, w_link_en, w_free_en, w_flush_en;
    logic [ADDR_WIDTH-1:0] w_new_next, w_link_val;
    logic [IDX_WIDTH-1:0]  w_link_idx, w_free_idx;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [ADDR_WIDTH-1:0] w_out_node, w_out_next;

    always_comb begin
        w_list_ok    = (int'(r_list) < NUM_LISTS);
        w_lidx       = w_list_ok ? r_list : '0;
        w_aidx       = (int'(r_addr) < MAX_NODE) ? r_addr[IDX_WIDTH-1:0] : '0;
        w_addr_ok    = (int'(r_addr) < MAX_NODE) && r_node_valid[w_aidx]
                       && (r_node_owner[w_aidx] == r_list);
        w_cur_head   = w_list_ok ? r_head[w_lidx] : c_null;
        w_cur_tail   = w_list_ok ? r_tail[w_lidx] : c_null;
        w_cur_len    = w_list_ok ? r_len[w_lidx]  : '0;
        w_empty      = (w_cur_len == '0);
        w_hidx       = (int'(w_cur_head) < MAX_NODE) ? w_cur_head[IDX_WIDTH-1:0] : '0;
        w_tidx       = (int'(w_cur_tail) < MAX_NODE) ? w_cur_tail[IDX_WIDTH-1:0] : '0;
        w_a_next     = r_node_next[w_aidx];
        w_vidx       = (int'(w_a_next) < MAX_NODE) ? w_a_next[IDX_WIDTH-1:0] : '0;
        w_alloc_addr = ADDR_WIDTH'(w_alloc_idx);

        w_fault    = 1'b0;
        w_head_n   = w_cur_head;
        w_tail_n   = w_cur_tail;
        w_len_n    = w_cur_len;
        w_new_en   = 1'b0;
        w_new_next = c_null;
        w_link_en  = 1'b0;
        w_link_idx = '0;
        w_link_val = c_null;
        w_free_en  = 1'b0;
        w_free_idx = '0;
        w_flush_en = 1'b0;
        w_out_data = data_out;
        w_out_node = node_addr;
        w_out_next = next_node_addr;

        if (!w_list_ok) begin
            w_fault = 1'b1;
        end else begin
            case (r_op)
                c_op_read: begin
                    if (!w_addr_ok) w_fault = 1'b1;
                    else begin
                        w_out_data = r_node_data[w_aidx];
                        w_out_node = r_addr;
                        w_out_next = w_a_next;
                    end
                end
                c_op_ins_head: begin
                    if (!w_alloc_ok) w_fault = 1'b1;
                    else begin
                        w_new_en   = 1'b1;
                        w_new_next = w_cur_head;
                        w_head_n   = w_alloc_addr;
                        if (w_empty) w_tail_n = w_alloc_addr;
                        w_len_n    = w_cur_len + c_one;
                        w_out_data = r_din;
                        w_out_node = w_alloc_addr;
                        w_out_next = w_cur_head;
                    end
                end
                c_op_ins_tail: begin
                    if (!w_alloc_ok) w_fault = 1'b1;
                    else begin
                        w_new_en = 1'b1;
                        if (w_empty) w_head_n = w_alloc_addr;
                        else begin
                            w_link_en  = 1'b1;
                            w_link_idx = w_tidx;
                            w_link_val = w_alloc_addr;
                        end
                        w_tail_n   = w_alloc_addr;
                        w_len_n    = w_cur_len + c_one;
                        w_out_data = r_din;
                        w_out_node = w_alloc_addr;
                        w_out_next = c_null;
                    end
                end
                c_op_pop_head: begin
                    if (w_empty) w_fault = 1'b1;
                    else begin
                        w_free_en  = 1'b1;
                        w_free_idx = w_hidx;
                        w_head_n   = r_node_next[w_hidx];
                        if (w_cur_len == c_one) w_tail_n = c_null;
                        w_len_n    = w_cur_len - c_one;
                        w_out_data = r_node_data[w_hidx];
                        w_out_node = w_cur_head;
                        w_out_next = c_null;
                    end
                end
                c_op_ins_aft: begin
                    if (!w_alloc_ok || !w_addr_ok) w_fault = 1'b1;
                    else begin
                        w_new_en   = 1'b1;
                        w_new_next = w_a_next;
                        w_link_en  = 1'b1;
                        w_link_idx = w_aidx;
                        w_link_val = w_alloc_addr;
                        if (r_addr == w_cur_tail) w_tail_n = w_alloc_addr;
                        w_len_n    = w_cur_len + c_one;
                        w_out_data = r_din;
                        w_out_node = w_alloc_addr;
                        w_out_next = w_a_next;
                    end
                end
                c_op_del_aft: begin
                    if (!w_addr_ok || (r_addr == w_cur_tail)) w_fault = 1'b1;
                    else begin
                        w_free_en  = 1'b1;
                        w_free_idx = w_vidx;
                        w_link_en  = 1'b1;
                        w_link_idx = w_aidx;
                        w_link_val = r_node_next[w_vidx];
                        if (w_a_next == w_cur_tail) w_tail_n = r_addr;
                        w_len_n    = w_cur_len - c_one;
                        w_out_data = r_node_data[w_vidx];
                        w_out_node = w_a_next;
                        w_out_next = c_null;
                    end
                end
                c_op_flush: begin
                    w_flush_en = 1'b1;
                    w_head_n   = c_null;
                    w_tail_n   = c_null;
                    w_len_n    = '0;
                    w_out_node = c_null;
                    w_out_next = c_null;
                end
                default: w_fault = 1'b1;
            endcase
        end
    end

    // ---------------- Storage and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_NODE; i++) begin
                r_node_valid[i] <= 1'b0;
                r_node_owner[i] <= '0;
                r_node_next[i]  <= c_null;
                r_node_data[i]  <= '0;
            end
            for (int l = 0; l < NUM_LISTS; l++) begin
                r_head[l] <= c_null;
                r_tail[l] <= c_null;
                r_len[l]  <= '0;
            end
            r_op           <= '0;
            r_list         <= '0;
            r_addr         <= '0;
            r_din          <= '0;
            fault          <= 1'b0;
            data_out       <= '0;
            node_addr      <= '0;
            next_node_addr <= '0;
            head           <= c_null;
            tail           <= c_null;
            length         <= '0;
        end else begin
            if (r_state == S_IDLE && op_start) begin
                r_op   <= op;
                r_list <= list_sel;
                r_addr <= addr_in;
                r_din  <= data_in;
            end
            if (r_state == S_EXEC) begin
                fault          <= w_fault;
                data_out       <= w_out_data;
                node_addr      <= w_out_node;
                next_node_addr <= w_out_next;
                head           <= w_head_n;
                tail           <= w_tail_n;
                length         <= w_len_n;
                if (!w_fault) begin
                    r_head[w_lidx] <= w_head_n;
                    r_tail[w_lidx] <= w_tail_n;
                    r_len[w_lidx]  <= w_len_n;
                end
                // Enables are only raised on fault-free commands.
                for (int i = 0; i < MAX_NODE; i++) begin
                    if ((w_flush_en && r_node_valid[i] && r_node_owner[i] == w_lidx) ||
                        (w_free_en && w_free_idx == IDX_WIDTH'(i))) begin
                        r_node_valid[i] <= 1'b0;
                        r_node_owner[i] <= '0;
                        r_node_next[i]  <= c_null;
                    end
                    if (w_link_en && w_link_idx == IDX_WIDTH'(i))
                        r_node_next[i] <= w_link_val;
                    if (w_new_en && w_alloc_idx == IDX_WIDTH'(i)) begin
                        r_node_valid[i] <= 1'b1;
                        r_node_owner[i] <= r_list;
                        r_node_next[i]  <= w_new_next;
                        r_node_data[i]  <= r_din;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_linked_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multi_linked_list                                       |
// | Description : Directed scoreboard bench for multi_linked_list.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_multi_linked_list;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst, op_start;
    logic [2:0] op;
    logic [1:0] list_sel;
    logic [4:0] addr_in;
    logic [7:0] data_in;
    logic       busy, op_done, fault, full;
    logic [7:0] data_out;
    logic [4:0] node_addr, next_node_addr, head, tail, length, free_count;
    logic [3:0] list_empty;

    multi_linked_list #(.DATA_WIDTH(8), .MAX_NODE(16), .NUM_LISTS(4)) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .op(op), .list_sel(list_sel),
        .addr_in(addr_in), .data_in(data_in), .busy(busy), .op_done(op_done),
        .fault(fault), .data_out(data_out), .node_addr(node_addr),
        .next_node_addr(next_node_addr), .head(head), .tail(tail), .length(length),
        .list_empty(list_empty), .full(full), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    flt;
        bit    chk_node;
        bit    chk_data;
        int    data, node, nxt, hd, tl, len, fc, emp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input int f, input bit cn, input bit cd,
                                input int d, input int nd, input int nx, input int h,
                                input int t, input int l, input int fc, input int em);
        exp_t e;
        e.name = nm; e.flt = f; e.chk_node = cn; e.chk_data = cd; e.data = d;
        e.node = nd; e.nxt = nx; e.hd = h; e.tl = t; e.len = l; e.fc = fc; e.emp = em;
        return e;
    endfunction

    // Monitor: every op_done pops one expectation.
    always @(negedge clk) begin
        if (op_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_op_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".fault"}, int'(fault), e.flt);
                chk({e.name, ".head"}, int'(head), e.hd);
                chk({e.name, ".tail"}, int'(tail), e.tl);
                chk({e.name, ".length"}, int'(length), e.len);
                chk({e.name, ".free_count"}, int'(free_count), e.fc);
                chk({e.name, ".full"}, int'(full), int'(e.fc == 0));
                chk({e.name, ".list_empty"}, int'(list_empty), e.emp);
                chk({e.name, ".busy"}, int'(busy), 1);
                if (e.chk_node) begin
                    chk({e.name, ".node_addr"}, int'(node_addr), e.node);
                    chk({e.name, ".next_node_addr"}, int'(next_node_addr), e.nxt);
                end
                if (e.chk_data) chk({e.name, ".data_out"}, int'(data_out), e.data);
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input int l, input int a, input int d,
                         input exp_t e, input bit hold);
        int n;
        @(negedge clk);
        op = o; list_sel = 2'(l); addr_in = 5'(a); data_in = 8'(d); op_start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) op_start = 1'b0;
        chk({e.name, ".busy_exec"}, int'(busy), 1);
        n = 1;
        while (!op_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        op_start = 1'b0;
        chk({e.name, ".latency"}, n, 2);
    endtask

    initial begin
        rst = 1'b1; op_start = 1'b0; op = '0; list_sel = '0; addr_in = '0; data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.op_done", int'(op_done), 0);
        chk("rst.fault", int'(fault), 0);
        chk("rst.data_out", int'(data_out), 0);
        chk("rst.node_addr", int'(node_addr), 0);
        chk("rst.next_node_addr", int'(next_node_addr), 0);
        chk("rst.head", int'(head), N);
        chk("rst.tail", int'(tail), N);
        chk("rst.length", int'(length), 0);
        chk("rst.free_count", int'(free_count), 16);
        chk("rst.list_empty", int'(list_empty), 4'hF);
        chk("rst.full", int'(full), 0);
        rst = 1'b0;

        // Build list0 by tail inserts
        do_op(3'd2, 0, 0, 'h11, mk("it_11", 0, 1, 0, 0, 0, N, 0, 0, 1, 15, 'b1110), 0);
        do_op(3'd2, 0, 0, 'h22, mk("it_22", 0, 1, 0, 0, 1, N, 0, 1, 2, 14, 'b1110), 0);
        do_op(3'd2, 0, 0, 'h33, mk("it_33", 0, 1, 0, 0, 2, N, 0, 2, 3, 13, 'b1110), 0);
        // Head insert / pop on list1
        do_op(3'd1, 1, 0, 'hAA, mk("ih_aa", 0, 1, 0, 0, 3, N, 3, 3, 1, 12, 'b1100), 0);
        do_op(3'd3, 1, 0, 0, mk("pop_aa", 0, 1, 1, 'hAA, 3, N, N, N, 0, 13, 'b1110), 0);
        // Insert-after tail, delete-after, reuse of freed node
        do_op(3'd4, 0, 2, 'h44, mk("ia_44", 0, 1, 0, 0, 3, N, 0, 3, 4, 12, 'b1110), 0);
        do_op(3'd0, 0, 2, 0, mk("rd_2", 0, 1, 1, 'h33, 2, 3, 0, 3, 4, 12, 'b1110), 0);
        do_op(3'd5, 0, 0, 0, mk("da_0", 0, 1, 1, 'h22, 1, N, 0, 3, 3, 13, 'b1110), 0);
        do_op(3'd0, 0, 0, 0, mk("rd_0", 0, 1, 1, 'h11, 0, 2, 0, 3, 3, 13, 'b1110), 0);
        do_op(3'd2, 0, 0, 'h55, mk("it_55", 0, 1, 0, 0, 1, N, 0, 1, 4, 12, 'b1110), 0);
        do_op(3'd2, 1, 0, 'h66, mk("it_66", 0, 1, 0, 0, 4, N, 4, 4, 1, 11, 'b1100), 0);
        do_op(3'd0, 1, 4, 0, mk("rd_4", 0, 1, 1, 'h66, 4, N, 4, 4, 1, 11, 'b1100), 0);
        // Faults: outputs hold previous values, no state change
        do_op(3'd0, 0, 4, 0, mk("f_owner", 1, 1, 1, 'h66, 4, N, 0, 1, 4, 11, 'b1100), 0);
        do_op(3'd5, 0, 1, 0, mk("f_del_tail", 1, 1, 1, 'h66, 4, N, 0, 1, 4, 11, 'b1100), 0);
        do_op(3'd7, 0, 0, 0, mk("f_op7", 1, 1, 1, 'h66, 4, N, 0, 1, 4, 11, 'b1100), 0);
        do_op(3'd3, 2, 0, 0, mk("f_pop_empty", 1, 1, 1, 'h66, 4, N, N, N, 0, 11, 'b1100), 0);
        do_op(3'd0, 0, 16, 0, mk("f_addr_null", 1, 1, 1, 'h66, 4, N, 0, 1, 4, 11, 'b1100), 0);
        // Fill the pool
        for (int k = 0; k < 4; k++)
            do_op(3'd2, 2, 0, 'hC0 + k,
                  mk($sformatf("fill2_%0d", k), 0, 1, 0, 0, 5 + k, N, 5, 5 + k, 1 + k, 10 - k, 'b1000), 0);
        for (int k = 0; k < 4; k++)
            do_op(3'd2, 3, 0, 'hD0 + k,
                  mk($sformatf("fill3_%0d", k), 0, 1, 0, 0, 9 + k, N, 9, 9 + k, 1 + k, 6 - k, 'b0000), 0);
        do_op(3'd1, 1, 0, 'hE0, mk("fill1_0", 0, 1, 0, 0, 13, 4, 13, 4, 2, 2, 'b0000), 0);
        do_op(3'd1, 1, 0, 'hE1, mk("fill1_1", 0, 1, 0, 0, 14, 13, 14, 4, 3, 1, 'b0000), 0);
        do_op(3'd1, 1, 0, 'hE2, mk("fill1_2", 0, 1, 0, 0, 15, 14, 15, 4, 4, 0, 'b0000), 0);
        do_op(3'd2, 0, 0, 'h77, mk("f_full_it", 1, 1, 0, 0, 15, 14, 0, 1, 4, 0, 'b0000), 0);
        do_op(3'd4, 2, 5, 'h78, mk("f_full_ia", 1, 1, 0, 0, 15, 14, 5, 8, 4, 0, 'b0000), 0);
        do_op(3'd6, 2, 0, 0, mk("flush2", 0, 1, 0, 0, N, N, N, N, 0, 4, 'b0100), 0);
        do_op(3'd1, 3, 0, 'h99, mk("ih_99", 0, 1, 0, 0, 5, 9, 5, 12, 5, 3, 'b0100), 0);
        do_op(3'd0, 3, 5, 0, mk("rd_5", 0, 1, 1, 'h99, 5, 9, 5, 12, 5, 3, 'b0100), 0);
        do_op(3'd6, 2, 0, 0, mk("flush2_empty", 0, 1, 0, 0, N, N, N, N, 0, 3, 'b0100), 0);

        // Reset during EXEC aborts the insert
        @(negedge clk);
        op = 3'd2; list_sel = 2'd0; data_in = 8'hBB; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        chk("abort.busy_exec", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", int'(busy), 0);
        chk("abort.free_count", int'(free_count), 16);
        chk("abort.list_empty", int'(list_empty), 4'hF);
        chk("abort.full", int'(full), 0);
        repeat (4) @(negedge clk);

        // op_start held while busy: only one command
        do_op(3'd2, 0, 0, 'hBB, mk("hold_it", 0, 1, 0, 0, 0, N, 0, 0, 1, 15, 'b1110), 1);
        repeat (5) @(negedge clk);
        chk("hold.free_count", int'(free_count), 15);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
